vector_checker: RTL and testbench
=================================

# vector_checker

Synthesizable stimulus/response stage that sits between the test-vector source and the DUT input/output pins (e.g. `and_4bit`). It accepts one vector `{a, b, expected}` at a time over a valid/ready handshake and drives `a`/`b` onto the DUT. After a fixed DUT latency it samples the DUT result, compares it against `expected`, counts vectors and mismatches, and reports pass/fail once the last vector has been checked.

## Interface
- `WIDTH`, 4: operand and result width.
- `DUT_LAT`, 0: extra cycles between driving the operands and sampling the result (legal range 0..15).
- `CNT_W`, 16: width of the vector and error counters.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `clear`  in  1  synchronous restart: returns to IDLE and zeroes the counters.
- `vec_valid`  in  1  a vector is presented.
- `vec_ready`  out  1  checker can accept a vector.
- `vec_a`, `vec_b`, `vec_exp`  in  WIDTH  operands and expected result.
- `vec_last`  in  1  marks the final vector of the run.
- `dut_a`, `dut_b`  out  WIDTH  registered operands driven to the DUT.
- `dut_c`  in  WIDTH  DUT result.
- `busy`  out  1  a vector is in flight (WAIT or COMPARE).
- `done`  out  1  run complete, sticky.
- `pass`  out  1  `done && err_cnt == 0`.
- `vec_cnt`, `err_cnt`  out  CNT_W  vectors compared and mismatches seen.
- `err_valid`  out  1  one-cycle pulse on a mismatch.
- `err_index`  out  CNT_W  0-based index of the mismatching vector.
- `err_got`, `err_exp`  out  WIDTH  captured DUT value and expected value.

## Operation
- FSM states: IDLE, WAIT, COMPARE, DONE.
- **IDLE**
  - `vec_ready = (state == IDLE) && !clear`.
  - On `vec_valid && vec_ready`, latch a/b/exp/last into registers; `dut_a`/`dut_b` are driven from these registers.
  - Load the wait counter with `DUT_LAT`, then go to WAIT, or straight to COMPARE if `DUT_LAT == 0`.
- **WAIT**: decrement the counter; at 1, go to COMPARE.
- **COMPARE**
  - Compare `dut_c` against the latched expected value with full-width equality.
  - `vec_cnt` increments.
  - On mismatch:
    - `err_cnt` increments.
    - `err_valid` pulses.
    - `err_index` is loaded with the pre-increment `vec_cnt`.
    - `err_got`/`err_exp` are loaded.
  - Next state is DONE if `last`, otherwise IDLE.
- **DONE**
  - `done = 1` and `vec_ready = 0`; state holds until `clear` or reset.
  - `dut_a`/`dut_b` hold their last values.
- Both counters saturate at all-ones and never wrap. `err_index` saturates with `vec_cnt`.
- `err_got`, `err_exp` and `err_index` hold their values until the next mismatch, `clear`, or reset.
- **`clear`**, in any state:
  - Next state is IDLE.
  - Counters, `done`, `err_valid` and the `err_*` fields are zeroed.
  - An in-flight vector is discarded and not counted.
  - `dut_a`/`dut_b` go to 0.
  - If `clear` and `vec_valid` arrive together, `clear` wins and the vector is not accepted.
- **Reset**: every output is 0 and state is IDLE. This includes `vec_ready`, which goes to 1 in the first cycle after reset is released. Reset mid-vector discards that vector.

## Timing
- A handshake at edge k presents the operands on `dut_a`/`dut_b` from edge k.
- `dut_c` is sampled at edge k+1+`DUT_LAT`; counters and the `err_*` outputs update at that same edge.
- Throughput is one vector per `DUT_LAT+2` cycles; `vec_ready` is low for `DUT_LAT+1` cycles after each acceptance.
- `done` and `pass` are valid from the edge that completes COMPARE of the last vector.

## Configuration
- `VECTOR_CHECKER_STOP_ON_ERR_EN` defined: a mismatch in COMPARE goes to DONE regardless of `last`, giving `done = 1` and `pass = 0`. Further vectors are refused until `clear`.
- Macro undefined: mismatches are counted and the run continues to the `last` vector.

## Structure
- Package `vector_checker_pkg` holds:
  - the state enum `vc_state_t`;
  - the localparam `VC_LAT_W = 4`;
  - the default `CNT_W`.
- One sub-module, `vc_sat_counter` (parameter width, inputs enable and clear, saturating), is instantiated twice: once for `vec_cnt` and once for `err_cnt`.

## Test plan
- `DUT_LAT = 0`, AND DUT, vectors `{1010, 0110, 0010}`, `{1111, 1111, 1111}` with `last` on the second: `done` at cycle 4, `vec_cnt = 2`, `err_cnt = 0`, `pass = 1`.
- Wrong expected value `{1100, 1010, 1111}`: `err_valid` pulses once with `err_got = 1000`, `err_exp = 1111`, `err_index = 0`; final `pass = 0`.
- `DUT_LAT = 3`, `vec_valid` held high: `vec_ready` is high one cycle in five; `dut_c` is sampled exactly 4 edges after acceptance.
- `clear` asserted mid-WAIT together with `vec_valid`: the next cycle is IDLE, counters are 0, and the vector is not accepted.
- Macro defined, 3 vectors with the 2nd mismatching: `done` after vector 2, `vec_cnt = 2`, `err_cnt = 1`, `vec_ready` stays 0.
- Reset pulsed during COMPARE: all outputs are 0; `vec_ready = 1` in the first cycle after reset is released.

Source files
------------

// File: rtl/vector_checker_pkg.sv
// Shared types and constants for the vector checker stage.
package vector_checker_pkg;

   // Width of the DUT latency down-counter (covers latencies 0..15).
   localparam int unsigned VC_LAT_W = 4;

   // Default width of the vector and error counters.
   localparam int unsigned VC_CNT_W = 16;

   typedef enum logic [1:0] {
      VC_IDLE    = 2'd0,
      VC_WAIT    = 2'd1,
      VC_COMPARE = 2'd2,
      VC_DONE    = 2'd3
   } vc_state_t;

endpackage

// File: rtl/vector_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module vc_sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] r_cnt;

   // Count enabled events, holding at all-ones instead of wrapping.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != '1)) begin
         r_cnt <= r_cnt + WIDTH'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/vector_checker.sv
// Stimulus/response checker: drives one {a, b} vector at a time onto a DUT,
// samples the result DUT_LAT+1 edges later and compares it to the expected value.
// Optional feature: define VECTOR_CHECKER_STOP_ON_ERR_EN to end the run on the
// first mismatch.
module vector_checker
   import vector_checker_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned DUT_LAT = 0,
   parameter int unsigned CNT_W   = VC_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_vec_valid,
   output logic             o_vec_ready,
   input  logic [WIDTH-1:0] i_vec_a,
   input  logic [WIDTH-1:0] i_vec_b,
   input  logic [WIDTH-1:0] i_vec_exp,
   input  logic             i_vec_last,
   output logic [WIDTH-1:0] o_dut_a,
   output logic [WIDTH-1:0] o_dut_b,
   input  logic [WIDTH-1:0] i_dut_c,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [CNT_W-1:0] o_vec_cnt,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic             o_err_valid,
   output logic [CNT_W-1:0] o_err_index,
   output logic [WIDTH-1:0] o_err_got,
   output logic [WIDTH-1:0] o_err_exp
);

   vc_state_t           r_state;
   vc_state_t           w_state_d;
   logic [VC_LAT_W-1:0] r_wait_cnt;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic [WIDTH-1:0]    r_exp;
   logic                r_last;
   logic                r_err_valid;
   logic [CNT_W-1:0]    r_err_index;
   logic [WIDTH-1:0]    r_err_got;
   logic [WIDTH-1:0]    r_err_exp;

   logic                w_accept;
   logic                w_cmp;
   logic                w_mismatch;
   logic                w_err;
   logic [CNT_W-1:0]    w_vec_cnt;
   logic [CNT_W-1:0]    w_err_cnt;

   // Ready is gated by reset so it reads 0 while reset is held.
   assign o_vec_ready = i_rst_n && (r_state == VC_IDLE) && !i_clear;
   assign w_accept    = i_vec_valid && o_vec_ready;
   assign w_cmp       = (r_state == VC_COMPARE);
   assign w_mismatch  = (i_dut_c != r_exp);
   assign w_err       = w_cmp && w_mismatch;

   // Next-state decode; clear overrides every transition.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         VC_IDLE: begin
            if (w_accept) begin
               w_state_d = (DUT_LAT == 0) ? VC_COMPARE : VC_WAIT;
            end
         end
         VC_WAIT: begin
            if (r_wait_cnt == VC_LAT_W'(1)) begin
               w_state_d = VC_COMPARE;
            end
         end
         VC_COMPARE: begin
`ifdef VECTOR_CHECKER_STOP_ON_ERR_EN
            w_state_d = (r_last || w_mismatch) ? VC_DONE : VC_IDLE;
`else
            w_state_d = r_last ? VC_DONE : VC_IDLE;
`endif
         end
         VC_DONE: begin
            w_state_d = VC_DONE;
         end
      endcase
      if (i_clear) begin
         w_state_d = VC_IDLE;
      end
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= VC_IDLE;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Latch the accepted vector; operands stay on the DUT pins until the next accept.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         r_a    <= '0;
         r_b    <= '0;
         r_exp  <= '0;
         r_last <= 1'b0;
      end else if (w_accept) begin
         r_a    <= i_vec_a;
         r_b    <= i_vec_b;
         r_exp  <= i_vec_exp;
         r_last <= i_vec_last;
      end
   end

   // DUT latency down-counter, loaded on accept and run only in WAIT.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         r_wait_cnt <= '0;
      end else if (w_accept) begin
         r_wait_cnt <= VC_LAT_W'(DUT_LAT);
      end else if (r_state == VC_WAIT) begin
         r_wait_cnt <= r_wait_cnt - VC_LAT_W'(1);
      end
   end

   // Capture mismatch details; index is the count before this vector is added.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         r_err_valid <= 1'b0;
         r_err_index <= '0;
         r_err_got   <= '0;
         r_err_exp   <= '0;
      end else begin
         r_err_valid <= w_err;
         if (w_err) begin
            r_err_index <= w_vec_cnt;
            r_err_got   <= i_dut_c;
            r_err_exp   <= r_exp;
         end
      end
   end

   vc_sat_counter #(
      .WIDTH (CNT_W)
   ) u_vec_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (i_clear),
      .i_en    (w_cmp),
      .o_cnt   (w_vec_cnt)
   );

   vc_sat_counter #(
      .WIDTH (CNT_W)
   ) u_err_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (i_clear),
      .i_en    (w_err),
      .o_cnt   (w_err_cnt)
   );

   assign o_dut_a     = r_a;
   assign o_dut_b     = r_b;
   assign o_busy      = (r_state == VC_WAIT) || (r_state == VC_COMPARE);
   assign o_done      = (r_state == VC_DONE);
   assign o_pass      = o_done && (w_err_cnt == '0);
   assign o_vec_cnt   = w_vec_cnt;
   assign o_err_cnt   = w_err_cnt;
   assign o_err_valid = r_err_valid;
   assign o_err_index = r_err_index;
   assign o_err_got   = r_err_got;
   assign o_err_exp   = r_err_exp;

endmodule

// File: tb/tb_vector_checker.sv
// Directed bench for vector_checker: u_dut0 (DUT_LAT=0, 4-bit AND DUT, 16-bit
// counters) and u_dut1 (DUT_LAT=3, bench-driven result, 2-bit counters).
module tb_vector_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // u_dut0 signals
   logic        rst0_n, clr0, v0_valid, v0_last, v0_ready;
   logic [3:0]  v0_a, v0_b, v0_exp, d0_a, d0_b, d0_c, e0_got, e0_exp;
   logic        v0_busy, v0_done, v0_pass, e0_valid;
   logic [15:0] c0_vec, c0_err, e0_idx;

   // u_dut1 signals
   logic        rst1_n, clr1, v1_valid, v1_last, v1_ready;
   logic [3:0]  v1_a, v1_b, v1_exp, d1_a, d1_b, d1_c, e1_got, e1_exp;
   logic        v1_busy, v1_done, v1_pass, e1_valid;
   logic [1:0]  c1_vec, c1_err, e1_idx;

   // AND gate as the device under check for u_dut0.
   assign d0_c = d0_a & d0_b;

   vector_checker #(.WIDTH(4), .DUT_LAT(0), .CNT_W(16)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst0_n), .i_clear(clr0),
      .i_vec_valid(v0_valid), .o_vec_ready(v0_ready),
      .i_vec_a(v0_a), .i_vec_b(v0_b), .i_vec_exp(v0_exp), .i_vec_last(v0_last),
      .o_dut_a(d0_a), .o_dut_b(d0_b), .i_dut_c(d0_c),
      .o_busy(v0_busy), .o_done(v0_done), .o_pass(v0_pass),
      .o_vec_cnt(c0_vec), .o_err_cnt(c0_err), .o_err_valid(e0_valid),
      .o_err_index(e0_idx), .o_err_got(e0_got), .o_err_exp(e0_exp)
   );

   vector_checker #(.WIDTH(4), .DUT_LAT(3), .CNT_W(2)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst1_n), .i_clear(clr1),
      .i_vec_valid(v1_valid), .o_vec_ready(v1_ready),
      .i_vec_a(v1_a), .i_vec_b(v1_b), .i_vec_exp(v1_exp), .i_vec_last(v1_last),
      .o_dut_a(d1_a), .o_dut_b(d1_b), .i_dut_c(d1_c),
      .o_busy(v1_busy), .o_done(v1_done), .o_pass(v1_pass),
      .o_vec_cnt(c1_vec), .o_err_cnt(c1_err), .o_err_valid(e1_valid),
      .o_err_index(e1_idx), .o_err_got(e1_got), .o_err_exp(e1_exp)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst0_n = 1'b0; clr0 = 1'b0; v0_valid = 1'b0; v0_last = 1'b0;
      v0_a = '0; v0_b = '0; v0_exp = '0;
      rst1_n = 1'b0; clr1 = 1'b0; v1_valid = 1'b0; v1_last = 1'b0;
      v1_a = '0; v1_b = '0; v1_exp = '0; d1_c = '0;
      tick();
      tick();

      // Reset state of u_dut0
      check("rst_ready", 32'(v0_ready), 0);
      check("rst_busy", 32'(v0_busy), 0);
      check("rst_done", 32'(v0_done), 0);
      check("rst_pass", 32'(v0_pass), 0);
      check("rst_vec_cnt", 32'(c0_vec), 0);
      check("rst_dut_a", 32'(d0_a), 0);
      rst0_n = 1'b1;
      rst1_n = 1'b1;
      #1;
      check("rel_ready", 32'(v0_ready), 1);

      // Two good vectors, last on the second
      v0_valid = 1'b1; v0_a = 4'b1010; v0_b = 4'b0110; v0_exp = 4'b0010; v0_last = 1'b0;
      tick();
      check("t1_dut_a", 32'(d0_a), 'hA);
      check("t1_dut_b", 32'(d0_b), 'h6);
      check("t1_ready_lo", 32'(v0_ready), 0);
      check("t1_busy", 32'(v0_busy), 1);
      v0_a = 4'b1111; v0_b = 4'b1111; v0_exp = 4'b1111; v0_last = 1'b1;
      tick();
      check("t1_vec_cnt1", 32'(c0_vec), 1);
      check("t1_ready_hi", 32'(v0_ready), 1);
      check("t1_no_err", 32'(e0_valid), 0);
      check("t1_not_done", 32'(v0_done), 0);
      tick();
      v0_valid = 1'b0;
      tick();
      check("t1_done", 32'(v0_done), 1);
      check("t1_vec_cnt2", 32'(c0_vec), 2);
      check("t1_err_cnt", 32'(c0_err), 0);
      check("t1_pass", 32'(v0_pass), 1);
      check("t1_done_ready", 32'(v0_ready), 0);
      tick();
      check("t1_done_sticky", 32'(v0_done), 1);
      check("t1_dut_a_hold", 32'(d0_a), 'hF);

      // Clear from DONE
      clr0 = 1'b1;
      #1;
      check("clr_ready_lo", 32'(v0_ready), 0);
      tick();
      check("clr_done", 32'(v0_done), 0);
      check("clr_vec_cnt", 32'(c0_vec), 0);
      check("clr_dut_a", 32'(d0_a), 0);
      clr0 = 1'b0;
      #1;
      check("clr_ready_hi", 32'(v0_ready), 1);

      // Single wrong expected value as the last vector
      v0_valid = 1'b1; v0_a = 4'b1100; v0_b = 4'b1010; v0_exp = 4'b1111; v0_last = 1'b1;
      tick();
      v0_valid = 1'b0;
      tick();
      check("t2_err_valid", 32'(e0_valid), 1);
      check("t2_err_got", 32'(e0_got), 'h8);
      check("t2_err_exp", 32'(e0_exp), 'hF);
      check("t2_err_index", 32'(e0_idx), 0);
      check("t2_err_cnt", 32'(c0_err), 1);
      check("t2_vec_cnt", 32'(c0_vec), 1);
      check("t2_done", 32'(v0_done), 1);
      check("t2_pass", 32'(v0_pass), 0);
      tick();
      check("t2_err_pulse", 32'(e0_valid), 0);
      check("t2_got_hold", 32'(e0_got), 'h8);

      // Mismatch on the second vector of a run: index 1
      clr0 = 1'b1;
      tick();
      clr0 = 1'b0;
      v0_valid = 1'b1; v0_a = 4'b1111; v0_b = 4'b1111; v0_exp = 4'b1111; v0_last = 1'b0;
      tick();
      v0_a = 4'b1111; v0_b = 4'b1110; v0_exp = 4'b1111;
      tick();
      tick();
      tick();
      check("t3_err_index", 32'(e0_idx), 1);
      check("t3_err_got", 32'(e0_got), 'hE);
      check("t3_err_cnt", 32'(c0_err), 1);
      check("t3_vec_cnt", 32'(c0_vec), 2);

      // Third vector accepted, then reset during its COMPARE
      v0_a = 4'b0101; v0_b = 4'b0101; v0_exp = 4'b0101;
      tick();
      v0_valid = 1'b0;
      rst0_n = 1'b0;
      #1;
      check("rc_ready_in_rst", 32'(v0_ready), 0);
      tick();
      check("rc_vec_cnt", 32'(c0_vec), 0);
      check("rc_err_cnt", 32'(c0_err), 0);
      check("rc_err_index", 32'(e0_idx), 0);
      check("rc_err_got", 32'(e0_got), 0);
      check("rc_err_exp", 32'(e0_exp), 0);
      check("rc_busy", 32'(v0_busy), 0);
      check("rc_done", 32'(v0_done), 0);
      check("rc_dut_a", 32'(d0_a), 0);
      rst0_n = 1'b1;
      #1;
      check("rc_ready_rel", 32'(v0_ready), 1);

`ifdef VECTOR_CHECKER_STOP_ON_ERR_EN
      // Stop on first error: vector 2 mismatches, vector 3 must be refused
      v0_valid = 1'b1; v0_a = 4'b0011; v0_b = 4'b0011; v0_exp = 4'b0011; v0_last = 1'b0;
      tick();
      v0_exp = 4'b0000;
      tick();
      tick();
      v0_exp = 4'b0011; v0_last = 1'b1;
      tick();
      check("se_done", 32'(v0_done), 1);
      check("se_pass", 32'(v0_pass), 0);
      check("se_vec_cnt", 32'(c0_vec), 2);
      check("se_err_cnt", 32'(c0_err), 1);
      tick();
      tick();
      check("se_ready", 32'(v0_ready), 0);
      check("se_vec_hold", 32'(c0_vec), 2);
      v0_valid = 1'b0;
`endif

      // u_dut1: latency 3, valid held high, counters saturate at 3
      check("l3_ready_init", 32'(v1_ready), 1);
      v1_valid = 1'b1;
      for (int v = 0; v < 5; v++) begin
         v1_a = 4'hC ^ 4'(v);
         v1_b = 4'hA + 4'(v);
         v1_exp = v1_a & v1_b;
         v1_last = (v == 4);
         d1_c = ~v1_exp;
         tick();
         check("l3_dut_a", 32'(d1_a), 32'(v1_a));
         check("l3_ready_e0", 32'(v1_ready), 0);
         tick();
         check("l3_ready_e1", 32'(v1_ready), 0);
         tick();
         check("l3_ready_e2", 32'(v1_ready), 0);
         tick();
         check("l3_ready_e3", 32'(v1_ready), 0);
         d1_c = v1_exp;
         tick();
         check("l3_vec_cnt", 32'(c1_vec), (v + 1 > 3) ? 3 : v + 1);
         check("l3_err_cnt", 32'(c1_err), 0);
         check("l3_ready_e4", 32'(v1_ready), (v < 4) ? 1 : 0);
      end
      v1_valid = 1'b0;
      check("l3_done", 32'(v1_done), 1);
      check("l3_pass", 32'(v1_pass), 1);

      // Clear mid-WAIT together with a presented vector
      clr1 = 1'b1;
      tick();
      clr1 = 1'b0;
      v1_valid = 1'b1; v1_a = 4'h7; v1_b = 4'h3; v1_exp = 4'h3; v1_last = 1'b0;
      tick();
      check("cw_busy", 32'(v1_busy), 1);
      check("cw_dut_a", 32'(d1_a), 'h7);
      clr1 = 1'b1;
      #1;
      check("cw_ready_clr", 32'(v1_ready), 0);
      tick();
      check("cw_idle", 32'(v1_busy), 0);
      check("cw_vec_cnt", 32'(c1_vec), 0);
      check("cw_dut_a0", 32'(d1_a), 0);
      check("cw_done", 32'(v1_done), 0);
      clr1 = 1'b0;
      v1_valid = 1'b0;
      #1;
      check("cw_ready", 32'(v1_ready), 1);
      tick();
      tick();
      tick();
      tick();
      check("cw_discard", 32'(c1_vec), 0);
      check("cw_still_idle", 32'(v1_busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
